bp_lite_to_burst_arb: RTL and testbench
=======================================

# bp_lite_to_burst_arb

Multi-channel BedRock Lite-to-Burst converter for the ME wormhole/adaptation layer. Arbitrates round-robin among `num_in_p` Lite masters, queues headers in a configurable-depth FIFO, and serialises each accepted message's data payload into out-width Burst beats, lowest word first. Successor to the single-channel converter, adding multiple inputs, deeper header buffering, back-to-back data bursts and a size check.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies paddr, lce_id and lce_assoc widths.
- `num_in_p`, default 2: Lite master channels, 1..8.
- `in_data_width_p`, no default: Lite data width.
- `out_data_width_p`, no default: Burst beat width. Must divide `in_data_width_p`.
- `payload_width_p`, no default: BedRock payload width.
- `payload_mask_p`, default 0: bit `t` set means msg_type `t` carries data.
- `hdr_els_p`, default 2: header FIFO depth, at least 2.
- `clk_i` in 1: clock. This is the only clock.
- `reset_n_i` in 1: reset, asynchronous assert, active-low.
- `in_msg_i` in `num_in_p*in_msg_width_lp`: Lite messages, channel 0 in the LSBs.
- `in_msg_v_i` in `num_in_p`: per-channel valid.
- `in_msg_ready_and_o` out `num_in_p`: per-channel ready.
- `out_msg_header_o` out `out_msg_header_width_lp`: Burst header.
- `out_msg_header_v_o` out 1; `out_msg_header_ready_and_i` in 1.
- `out_msg_data_o` out `out_data_width_p`: Burst data beat.
- `out_msg_data_v_o` out 1; `out_msg_data_ready_and_i` in 1.
- `error_o` out 1: sticky oversize-message flag.

## Operation
- **Grant:** the grant goes to the first valid channel at or after `rr_ptr`. It is computed combinationally from `in_msg_v_i`. Only the granted channel's ready may be 1.
- **Accept condition:** a message is accepted when all of these hold:
  - the granted channel is valid;
  - the header FIFO is not full;
  - either `has_data=0`, or the serializer is idle, or the serializer is on its last beat with a data handshake this cycle.
- **Full FIFO:** a full FIFO does not accept, even if a header pop happens the same cycle.
- **On accept:**
  - `rr_ptr` is set to granted+1 mod `num_in_p`.
  - The header is enqueued, passed through unchanged.
  - If `has_data`, the data is loaded into the serializer and `beats` is loaded.
- **Beat count:** `beats = max(1, 2^size / out_bytes)`, clamped to `burst_words = in/out`.
  - The counter width is `clog2(burst_words)+1`.
  - The beat index wraps to 0 when a burst finishes.
- **Serializer states:**
  - `IDLE`: on accept of a data message, go to `SEND`.
  - `SEND`: stay while beats remain. On the last beat's handshake, go to `IDLE`, or reload and stay in `SEND` if a data message is accepted the same cycle.
- **Data stability:** the data output is held stable while `out_msg_data_v_o=1` and ready is 0.
- **Ordering:** headers and data each leave in accept order. The header stream may run up to `hdr_els_p` messages ahead of the data stream.
- **Independence:** the header and data outputs are decoupled; neither waits for the other.

## Timing
- **Reset values:** all ready and valid outputs are 0, `error_o=0`, `rr_ptr=0`, the FIFO is empty, the serializer is `IDLE`. Reset acts asynchronously mid-burst; partial bursts are discarded.
- **Header latency:** `out_msg_header_v_o` rises 1 cycle after accept.
- **Data latency:** beat 0 is valid 1 cycle after accept. Each following beat is valid the cycle after the previous beat's handshake.
- **Throughput:** data messages sustain 100% beat throughput back-to-back. Data-less messages can be accepted 1 per cycle while the FIFO has space.
- **Handshakes:** ready-valid-and on all ports. Inputs must hold stable while valid and not ready.

## Configuration
- **`BP_LITE_TO_BURST_SIZE_CHECK_EN` defined:**
  - A message with `2^size > in_data_width_p/8` sets `error_o` on accept.
  - `error_o` stays set until reset.
  - The message is still forwarded, with `beats` clamped.
- **Undefined:** `error_o` is tied to 0 and there is no check logic. Clamping still applies.

## Structure
- **Shared declarations:** BedRock header, message and width typedefs come from the existing `declare_bp_bedrock_if` macros.
- **Package addition:** a `bp_me_pkg` function computing burst beat count from (size, out bytes, max beats), reusable by other burst adapters.
- **Sub-module:** one natural sub-module, `bp_burst_serializer`: the parallel-load shift register, beat counter and last-beat reload.
- **Header FIFO:** the existing small 1r1w FIFO.

## Test plan
- **Single 64B write:** in=512, out=64, ch0 write with size=64B and data words 0..7. Expect the header 1 cycle later, then 8 beats with values 0,1,…,7.
- **Small sizes:** size=8B, then size=2B. Expect exactly 1 beat each, containing the low 64 bits.
- **Round-robin:** ch0 and ch1 hold no-data reads valid continuously, header ready=1. Expect grants 0,1,0,1,… and 1 accept per cycle.
- **FIFO full:** `hdr_els_p=2`, header ready=0, three reads. Expect 2 accepted and ready=0 for the third. The third is accepted the cycle after the first header pop.
- **Data backpressure:** a 64B write with data ready low 3 cycles at beat 4, and a second 64B write queued. Expect beat 4 held. The second write is accepted on the beat-7 handshake and its beat 0 appears the next cycle.
- **Oversize and reset:** a 128B write with the macro defined gives `error_o=1` and 8 beats; without the macro, `error_o=0`. Asserting `reset_n_i` mid-burst drops all valids immediately.

Source files
------------

// File: rtl/bp_lite_to_burst_arb_pkg.sv
// Shared types and helpers for the multi-channel BedRock Lite-to-Burst arbiter.
// Header layout (LSB first): msg_type, size, paddr, payload.
package bp_lite_to_burst_arb_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  localparam int msg_type_width_gp = 4;
  localparam int msg_size_width_gp = 3;

  typedef enum logic {
    e_ser_idle = 1'b0,
    e_ser_send = 1'b1
  } ser_state_e;

  function automatic int paddr_width(bp_params_e cfg);
    return (cfg == e_bp_small_cfg) ? 32 : 40;
  endfunction

  function automatic int header_width(bp_params_e cfg, int payload_width);
    return msg_type_width_gp + msg_size_width_gp + paddr_width(cfg) + payload_width;
  endfunction

  // Beats for a 2^size byte payload on out_bytes-wide beats: at least one, at most max_beats.
  function automatic int burst_beats(int size, int out_bytes, int max_beats);
    int n;
    n = (1 << size) / out_bytes;
    if (n < 1) n = 1;
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

endpackage

// File: rtl/bp_lite_to_burst_arb_serializer.sv
// bp_burst_serializer: parallel-load shift register emitting the lowest out-width word first,
// with a beat counter that can reload on the last beat's handshake for back-to-back bursts.
module bp_burst_serializer
  import bp_lite_to_burst_arb_pkg::*;
#(
  parameter int in_width_p  = 512,
  parameter int out_width_p = 64,
  parameter int cnt_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic [in_width_p-1:0]  data_i,
  input  logic [cnt_width_p-1:0] beats_i,
  output logic                   can_load_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   v_o,
  input  logic                   ready_and_i
);

  ser_state_e             state_q, state_d;
  logic [in_width_p-1:0]  shift_q, shift_d;
  logic [cnt_width_p-1:0] beats_q, beats_d;
  logic                   handshake;
  logic                   last_beat;

  assign handshake  = (state_q == e_ser_send) && ready_and_i;
  assign last_beat  = (beats_q == cnt_width_p'(1));
  assign can_load_o = (state_q == e_ser_idle) || (handshake && last_beat);
  assign v_o        = (state_q == e_ser_send);
  assign data_o     = shift_q[out_width_p-1:0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beats_d = beats_q;
    case (state_q)
      e_ser_idle: begin
        if (load_i) begin
          state_d = e_ser_send;
          shift_d = data_i;
          beats_d = beats_i;
        end
      end
      e_ser_send: begin
        if (handshake) begin
          if (last_beat) begin
            // A message accepted on the final handshake starts its burst without a bubble.
            if (load_i) begin
              shift_d = data_i;
              beats_d = beats_i;
            end else begin
              state_d = e_ser_idle;
              beats_d = '0;
            end
          end else begin
            shift_d = shift_q >> out_width_p;
            beats_d = beats_q - cnt_width_p'(1);
          end
        end
      end
      default: state_d = e_ser_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ser_idle;
      shift_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: rtl/bp_lite_to_burst_arb.sv
// Round-robin Lite-to-Burst converter: header FIFO plus data serializer per accepted message.
// Optional oversize check enabled by defining BP_LITE_TO_BURST_SIZE_CHECK_EN.
module bp_lite_to_burst_arb
  import bp_lite_to_burst_arb_pkg::*;
#(
  parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
  parameter int          num_in_p         = 2,
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter int          payload_width_p  = 8,
  parameter logic [15:0] payload_mask_p   = 16'h0000,
  parameter int          hdr_els_p        = 2,
  localparam int out_msg_header_width_lp = header_width(bp_params_p, payload_width_p),
  localparam int in_msg_width_lp         = out_msg_header_width_lp + in_data_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_in_p*in_msg_width_lp-1:0]   in_msg_i,
  input  logic [num_in_p-1:0]                   in_msg_v_i,
  output logic [num_in_p-1:0]                   in_msg_ready_and_o,
  output logic [out_msg_header_width_lp-1:0]    out_msg_header_o,
  output logic                                  out_msg_header_v_o,
  input  logic                                  out_msg_header_ready_and_i,
  output logic [out_data_width_p-1:0]           out_msg_data_o,
  output logic                                  out_msg_data_v_o,
  input  logic                                  out_msg_data_ready_and_i,
  output logic                                  error_o
);

  localparam int burst_words_lp     = in_data_width_p / out_data_width_p;
  localparam int beat_cnt_width_lp  = $clog2(burst_words_lp) + 1;
  localparam int out_bytes_lp       = out_data_width_p / 8;
  localparam int ptr_width_lp       = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int fifo_ptr_width_lp  = $clog2(hdr_els_p);
  localparam int fifo_cnt_width_lp  = $clog2(hdr_els_p + 1);

  logic [ptr_width_lp-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ptr_width_lp-1:0]            grant_idx;
  logic                               grant_v;
  int                                 best_off;
  int                                 cur_off;
  logic [in_msg_width_lp-1:0]         grant_msg;
  logic [out_msg_header_width_lp-1:0] grant_hdr;
  logic [in_data_width_p-1:0]         grant_data;
  logic [msg_type_width_gp-1:0]       grant_type;
  logic [msg_size_width_gp-1:0]       grant_size;
  logic [beat_cnt_width_lp-1:0]       grant_beats;
  logic                               has_data;
  logic                               accept_ok;
  logic                               accept;
  logic                               ser_can_load;

  logic [out_msg_header_width_lp-1:0] hdr_mem_q [hdr_els_p];
  logic [fifo_ptr_width_lp-1:0]       wr_ptr_q, wr_ptr_d;
  logic [fifo_ptr_width_lp-1:0]       rd_ptr_q, rd_ptr_d;
  logic [fifo_cnt_width_lp-1:0]       count_q, count_d;
  logic                               fifo_full;
  logic                               hdr_pop;

  // Smallest rotated distance from rr_ptr among valid channels wins.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    best_off  = num_in_p;
    cur_off   = 0;
    for (int c = 0; c < num_in_p; c++) begin
      cur_off = (c + num_in_p - int'(rr_ptr_q)) % num_in_p;
      if (in_msg_v_i[c] && (cur_off < best_off)) begin
        best_off  = cur_off;
        grant_v   = 1'b1;
        grant_idx = ptr_width_lp'(c);
      end
    end
  end

  always_comb begin
    grant_msg = '0;
    for (int c = 0; c < num_in_p; c++) begin
      if (grant_idx == ptr_width_lp'(c)) begin
        grant_msg = in_msg_i[c*in_msg_width_lp +: in_msg_width_lp];
      end
    end
  end

  assign grant_hdr   = grant_msg[out_msg_header_width_lp-1:0];
  assign grant_data  = grant_msg[in_msg_width_lp-1 -: in_data_width_p];
  assign grant_type  = grant_hdr[msg_type_width_gp-1:0];
  assign grant_size  = grant_hdr[msg_type_width_gp +: msg_size_width_gp];
  assign has_data    = payload_mask_p[grant_type];
  assign grant_beats = beat_cnt_width_lp'(burst_beats(int'(grant_size), out_bytes_lp, burst_words_lp));

  assign fifo_full = (count_q == fifo_cnt_width_lp'(hdr_els_p));
  assign hdr_pop   = (count_q != '0) && out_msg_header_ready_and_i;
  // A pop in the same cycle does not free a slot for the incoming header.
  assign accept_ok = reset_n_i && !fifo_full && (!has_data || ser_can_load);
  assign accept    = grant_v && accept_ok;

  for (genvar gi = 0; gi < num_in_p; gi++) begin : g_ready
    assign in_msg_ready_and_o[gi] = accept_ok && grant_v && (grant_idx == ptr_width_lp'(gi));
  end

  function automatic logic [fifo_ptr_width_lp-1:0] fifo_next(input logic [fifo_ptr_width_lp-1:0] p);
    return (int'(p) == hdr_els_p - 1) ? '0 : p + fifo_ptr_width_lp'(1);
  endfunction

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      rr_ptr_d = (int'(grant_idx) == num_in_p - 1) ? '0 : grant_idx + ptr_width_lp'(1);
      wr_ptr_d = fifo_next(wr_ptr_q);
    end
    if (hdr_pop) begin
      rd_ptr_d = fifo_next(rd_ptr_q);
    end
    case ({accept, hdr_pop})
      2'b10:   count_d = count_q + fifo_cnt_width_lp'(1);
      2'b01:   count_d = count_q - fifo_cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hdr_mem_q[wr_ptr_q] <= grant_hdr;
    end
  end

  assign out_msg_header_o   = hdr_mem_q[rd_ptr_q];
  assign out_msg_header_v_o = (count_q != '0);

  bp_burst_serializer #(
    .in_width_p  (in_data_width_p),
    .out_width_p (out_data_width_p),
    .cnt_width_p (beat_cnt_width_lp)
  ) u_serializer (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (accept && has_data),
    .data_i      (grant_data),
    .beats_i     (grant_beats),
    .can_load_o  (ser_can_load),
    .data_o      (out_msg_data_o),
    .v_o         (out_msg_data_v_o),
    .ready_and_i (out_msg_data_ready_and_i)
  );

`ifdef BP_LITE_TO_BURST_SIZE_CHECK_EN
  localparam int in_bytes_log2_lp = $clog2(in_data_width_p / 8);

  logic error_q, error_d;

  always_comb begin
    error_d = error_q;
    if (accept && (int'(grant_size) > in_bytes_log2_lp)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_lite_to_burst_arb.sv
// Scoreboard bench: expected headers/beats are queued at accept and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_bp_lite_to_burst_arb;

  localparam int NUM_IN  = 2;
  localparam int IN_W    = 512;
  localparam int OUT_W   = 64;
  localparam int PL_W    = 8;
  localparam int HDR_ELS = 2;
  localparam int HDR_W   = 4 + 3 + 40 + PL_W;
  localparam int MSG_W   = HDR_W + IN_W;
  localparam logic [15:0] MASK = 16'h000A;

  typedef struct {
    logic [3:0]      typ;
    logic [2:0]      size;
    logic [39:0]     addr;
    logic [PL_W-1:0] pl;
    logic [IN_W-1:0] data;
  } msg_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_IN*MSG_W-1:0] in_msg;
  logic [NUM_IN-1:0]       in_v;
  logic [NUM_IN-1:0]       in_rdy;
  logic [HDR_W-1:0]        hdr_o;
  logic                    hdr_v;
  logic                    hdr_rdy;
  logic [OUT_W-1:0]        data_o;
  logic                    data_v;
  logic                    data_rdy;
  logic                    error;

  bp_lite_to_burst_arb #(
    .num_in_p         (NUM_IN),
    .in_data_width_p  (IN_W),
    .out_data_width_p (OUT_W),
    .payload_width_p  (PL_W),
    .payload_mask_p   (MASK),
    .hdr_els_p        (HDR_ELS)
  ) dut (
    .clk_i                      (clk),
    .reset_n_i                  (reset_n),
    .in_msg_i                   (in_msg),
    .in_msg_v_i                 (in_v),
    .in_msg_ready_and_o         (in_rdy),
    .out_msg_header_o           (hdr_o),
    .out_msg_header_v_o         (hdr_v),
    .out_msg_header_ready_and_i (hdr_rdy),
    .out_msg_data_o             (data_o),
    .out_msg_data_v_o           (data_v),
    .out_msg_data_ready_and_i   (data_rdy),
    .error_o                    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  msg_t             chan_q [NUM_IN][$];
  logic [HDR_W-1:0] hdr_exp_q [$];
  logic [OUT_W-1:0] dat_exp_q [$];
  bit               acc_flag [NUM_IN];
  int               rr_m = 0;
  bit               err_m = 1'b0;
  int               hmode = 0;
  int               dmode = 0;
  int               beats_seen = 0;
  int               stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [HDR_W-1:0] pack_hdr(input msg_t m);
    return {m.pl, m.addr, m.size, m.typ};
  endfunction

  // Writes (types 1 and 3) carry data.
  function automatic bit carries_data(input logic [3:0] t);
    return (t == 4'd1) || (t == 4'd3);
  endfunction

  // 2^size bytes split into 8-byte beats, at least one, at most a full 512-bit word.
  function automatic int n_beats(input logic [2:0] s);
    int n;
    n = (1 << s) / 8;
    if (n == 0) n = 1;
    if (n > 8) n = 8;
    return n;
  endfunction

  function automatic msg_t mk(input int typ, input int size);
    msg_t m;
    logic [63:0] a;
    m.typ  = 4'(typ);
    m.size = 3'(size);
    a      = {$urandom, $urandom};
    m.addr = a[39:0];
    m.pl   = PL_W'($urandom);
    for (int k = 0; k < 16; k++) m.data[32*k +: 32] = $urandom;
    return m;
  endfunction

  // Monitor: compare outputs against the model, then record this cycle's accepts.
  int               hocc, docc, gch, ach;
  bit               gv, dhs, exp_ok, held_v;
  logic [NUM_IN-1:0] exp_rdy, acc_vec;
  logic [OUT_W-1:0] held_data, exp_d;
  logic [HDR_W-1:0] exp_h;
  msg_t             gm, am;

  always @(negedge clk) begin
    for (int c = 0; c < NUM_IN; c++) acc_flag[c] = 1'b0;
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      hocc = hdr_exp_q.size();
      docc = dat_exp_q.size();
      dhs  = data_v && data_rdy;
      chk("hdr_valid", 64'(hdr_v), 64'(hocc != 0));
      chk("data_valid", 64'(data_v), 64'(docc != 0));
      chk("error_flag", 64'(error), 64'(err_m));
      if (held_v && data_v) chk("data_hold", data_o, held_data);
      held_v    = data_v && !data_rdy;
      held_data = data_o;
      if (hdr_v && hdr_rdy && hocc != 0) begin
        exp_h = hdr_exp_q.pop_front();
        chk("header", 64'(hdr_o), 64'(exp_h));
      end
      if (dhs && docc != 0) begin
        exp_d = dat_exp_q.pop_front();
        chk("beat", data_o, exp_d);
        beats_seen++;
      end
      gv  = 1'b0;
      gch = 0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (((in_v >> ((rr_m + k) % NUM_IN)) & 1) != 0) begin
          gv  = 1'b1;
          gch = (rr_m + k) % NUM_IN;
        end
      end
      exp_ok = 1'b0;
      if (gv && chan_q[gch].size() > 0) begin
        gm     = chan_q[gch][0];
        exp_ok = (hocc < HDR_ELS) &&
                 (!carries_data(gm.typ) || docc == 0 || (docc == 1 && dhs));
      end
      exp_rdy = exp_ok ? NUM_IN'(1 << gch) : '0;
      chk("ready", 64'(in_rdy), 64'(exp_rdy));
      acc_vec = in_v & in_rdy;
      ach = -1;
      for (int c = 0; c < NUM_IN; c++) if (((acc_vec >> c) & 1) != 0) ach = c;
      if (ach >= 0 && chan_q[ach].size() > 0) begin
        am = chan_q[ach][0];
        acc_flag[ach] = 1'b1;
        rr_m = (ach + 1) % NUM_IN;
        hdr_exp_q.push_back(pack_hdr(am));
        if (carries_data(am.typ)) begin
          for (int k = 0; k < n_beats(am.size); k++) dat_exp_q.push_back(am.data[64*k +: 64]);
        end
`ifdef BP_LITE_TO_BURST_SIZE_CHECK_EN
        if (am.size == 3'd7) err_m = 1'b1;
`endif
      end
    end
  end

  // Driver: retire accepted messages and present each channel's queue head.
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_IN; c++) begin
        if (acc_flag[c] && chan_q[c].size() > 0) void'(chan_q[c].pop_front());
        if (chan_q[c].size() > 0) begin
          in_v[c] = 1'b1;
          in_msg[c*MSG_W +: MSG_W] = {chan_q[c][0].data, pack_hdr(chan_q[c][0])};
        end else begin
          in_v[c] = 1'b0;
          in_msg[c*MSG_W +: MSG_W] = '0;
        end
      end
      case (hmode)
        0:       hdr_rdy = 1'b1;
        1:       hdr_rdy = ($urandom % 3) != 0;
        default: hdr_rdy = 1'b0;
      endcase
      case (dmode)
        0: data_rdy = 1'b1;
        1: data_rdy = ($urandom % 4) != 0;
        default: begin
          if (beats_seen == 4 && stall_cnt < 3) begin
            data_rdy = 1'b0;
            stall_cnt++;
          end else begin
            data_rdy = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      step();
      n++;
      busy = chan_q[0].size() != 0 || chan_q[1].size() != 0 ||
             hdr_exp_q.size() != 0 || dat_exp_q.size() != 0;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    msg_t m;
    int   n;
    reset_n  = 1'b0;
    in_v     = '0;
    in_msg   = '0;
    hdr_rdy  = 1'b0;
    data_rdy = 1'b0;
    repeat (3) step();
    chk("rst_ready", 64'(in_rdy), 64'(0));
    chk("rst_hdr_v", 64'(hdr_v), 64'(0));
    chk("rst_data_v", 64'(data_v), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    reset_n = 1'b1;
    step();

    // Single 64B write with words 0..7.
    m = mk(1, 6);
    for (int k = 0; k < 8; k++) m.data[64*k +: 64] = 64'(k);
    chan_q[0].push_back(m);
    drain("drain_64b", 200);

    // 8B and 2B writes: one beat each.
    chan_q[0].push_back(mk(1, 3));
    chan_q[0].push_back(mk(3, 1));
    drain("drain_small", 200);

    // Round-robin between two channels of reads.
    for (int i = 0; i < 6; i++) begin
      chan_q[0].push_back(mk(0, 3));
      chan_q[1].push_back(mk(2, 3));
    end
    drain("drain_rr", 200);

    // Header FIFO full with header ready held low.
    hmode = 2;
    step();
    for (int i = 0; i < 3; i++) chan_q[0].push_back(mk(0, 2));
    repeat (6) step();
    chk("fifo_full_stall", 64'(in_rdy), 64'(0));
    chk("fifo_full_hdr_v", 64'(hdr_v), 64'(1));
    hmode = 0;
    drain("drain_fifo", 200);

    // Data backpressure at beat 4, second write queued behind.
    beats_seen = 0;
    stall_cnt  = 0;
    dmode      = 2;
    chan_q[0].push_back(mk(1, 6));
    chan_q[0].push_back(mk(3, 6));
    drain("drain_bp", 300);
    dmode = 0;

    // Randomised traffic with random backpressure on both outputs.
    hmode = 1;
    dmode = 1;
    for (int i = 0; i < 80; i++) begin
      chan_q[$urandom_range(0, NUM_IN - 1)].push_back(mk($urandom_range(0, 3), $urandom_range(0, 7)));
    end
    drain("drain_rand", 20000);
    hmode = 0;
    dmode = 0;

    // Oversize 128B write: clamped to 8 beats.
    chan_q[1].push_back(mk(1, 7));
    drain("drain_oversize", 200);
    chk("oversize_error", 64'(error), 64'(err_m));

    // Reset mid-burst.
    dmode = 1;
    chan_q[0].push_back(mk(1, 6));
    n = 0;
    while (!data_v && n < 50) begin
      step();
      n++;
    end
    chk("burst_started", 64'(data_v), 64'(1));
    step();
    step();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_data_v", 64'(data_v), 64'(0));
    chk("rst_mid_hdr_v", 64'(hdr_v), 64'(0));
    chk("rst_mid_ready", 64'(in_rdy), 64'(0));
    chk("rst_mid_error", 64'(error), 64'(0));
    for (int c = 0; c < NUM_IN; c++) chan_q[c].delete();
    hdr_exp_q.delete();
    dat_exp_q.delete();
    rr_m  = 0;
    err_m = 1'b0;
    dmode = 0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Traffic after reset starts cleanly from channel 0.
    chan_q[1].push_back(mk(0, 3));
    chan_q[0].push_back(mk(3, 5));
    drain("drain_post_rst", 200);
    chk("final_error", 64'(error), 64'(err_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
